pcs_10g_tx_gearbox: RTL and testbench
=====================================

Name: pcs_10g_tx_gearbox

Overview:
- TX-side 66b→64b gearbox for the 10GBASE-R PCS. It is the counterpart of the RX gearbox/block-sync path.
- Accepts one 66-bit block per cycle: 2-bit sync header plus 64-bit scrambled payload.
- Emits a continuous 64-bit parallel word to the SerDes.
- Every 33 output cycles carry exactly 32 blocks, so input is back-pressured for one cycle in 33.

Parameters:
- DATA_W, 64, payload width and output word width. Only 64 is supported.
- HEAD_W, 2, sync header width.
- SEQ_W, 6, sequence counter width. Must hold 0..32.

Ports:
- clk  in  1  parallel clock.
- nreset  in  1  asynchronous active-low reset.
- valid_i  in  1  a block is presented on head_i/data_i.
- head_i  in  HEAD_W  sync header; 2'b01 = data, 2'b10 = ctrl.
- data_i  in  DATA_W  scrambled block payload.
- ready_o  out  1  gearbox accepts a block this cycle.
- valid_o  out  1  tx_par_data_o is valid this cycle.
- tx_par_data_o  out  DATA_W  output word to the SerDes; LSB is transmitted first.
- head_err_o  out  1  present only with the optional feature (see below).

Behaviour:
- Reset (async assert, sync release): seq=0, leftover buffer=0, valid_o=0, tx_par_data_o=0, ready_o=1 (combinational from seq), head_err_o=0.
- Block view: B = {data_i, head_i}, 66 bits. The header occupies the lowest 2 bits and is transmitted first.
- State:
  - seq 0..32.
  - leftover register L, 64 bits. Valid width is 2*seq bits, LSB-aligned.
- ready_o = (seq != 32). It is purely a function of seq.
- Transfer = valid_i && ready_o. On a transfer at seq=s (0..31):
  - tx_par_data_o <= ((B << 2s) | L[2s-1:0])[63:0];
  - L <= B >> (64-2s), giving 2s+2 bits;
  - seq <= s+1;
  - valid_o <= 1.
- At seq=32:
  - inputs are ignored;
  - tx_par_data_o <= L (64 bits);
  - L <= 0, seq <= 0, valid_o <= 1.
- Stall: valid_i=0 while ready_o=1 → seq and L hold, valid_o <= 0, tx_par_data_o holds its last value. Upstream must not stall in steady state; a stall breaks line continuity by design.
- seq=32 is independent of valid_i: the flush word is always emitted.
- Latency: 1 cycle from the transfer to the first word containing the block's header.
- Wrap: after 33 output words, seq returns to 0 and bit alignment restarts with the header at bit 0.
- Reset mid-sequence discards L and any partially sent block. The next block starts at bit 0.
- Header values are not validated in the baseline; all 4 codes pass through.

Optional Feature:
- Macro: PCS_TX_GEARBOX_HEAD_CHECK_EN.
- With the macro defined:
  - head_err_o port exists.
  - On a transfer where head_i is 2'b00 or 2'b11, head_err_o <= 1 for one cycle.
  - The header is forced to 2'b10 (ctrl) in the output stream, so the receiver sees an errored ctrl block rather than a sync slip.
  - head_err_o <= 0 otherwise.
- Without the macro: no head_err_o port, no check, header passed through unchanged.

Decomposition:
- Shared package pcs_pkg holds:
  - DATA_W, HEAD_W, BLOCK_W = 66;
  - SYNC_CTRL = 2'b10, SYNC_DATA = 2'b01;
  - GB_SEQ_MAX = 32.
- Same package is used by the RX gearbox and the loopback top.
- Single module; no sub-module is warranted. The shift/merge stays in one always_comb block.

Test Plan:
- Reset then valid_i=1 with head_i=2'b01, data_i=64'h0123456789ABCDEF → cycle after transfer: tx_par_data_o=64'h048D159E26AF37BD (B[63:0]), valid_o=1, seq=1.
- 32 consecutive blocks with valid_i=1 → ready_o low exactly on the 33rd cycle; 33 valid words out; concatenating all 33 outputs (LSB first) equals the 32 blocks {data,head} concatenated, 2112 bits.
- valid_i=0 for 3 cycles at seq=5 → valid_o=0 for those cycles, tx_par_data_o unchanged; resuming gives an identical bitstream with the gap removed.
- nreset pulsed at seq=17 → all outputs 0 during reset; first block after release appears at bit 0 with seq=1.
- Back-to-back 100 random blocks through this gearbox into the RX gearbox/block sync (loopback) → RX locks and every 66-bit block matches.
- With PCS_TX_GEARBOX_HEAD_CHECK_EN: head_i=2'b11 → head_err_o=1 for one cycle and the emitted header bits are 2'b10; head_i=2'b01 → head_err_o=0.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS constants, used by the TX/RX gearboxes and the loopback top.
package pcs_pkg;

  localparam int DATA_W     = 64;
  localparam int HEAD_W     = 2;
  localparam int BLOCK_W    = HEAD_W + DATA_W;
  localparam int GB_SEQ_MAX = 32;

  localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b10;
  localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b01;

endpackage

// File: rtl/pcs_10g_tx_gearbox.sv
// 10GBASE-R TX 66b->64b gearbox: 32 blocks in, 33 words out, one back-pressure cycle in 33.
// Define PCS_TX_GEARBOX_HEAD_CHECK_EN to add head_err_o and force illegal headers to ctrl.
module pcs_10g_tx_gearbox #(
  parameter int DATA_W = pcs_pkg::DATA_W,
  parameter int HEAD_W = pcs_pkg::HEAD_W,
  parameter int SEQ_W  = 6
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
`ifdef PCS_TX_GEARBOX_HEAD_CHECK_EN
  output logic              head_err_o,
`endif
  output logic [DATA_W-1:0] tx_par_data_o
);

  import pcs_pkg::SYNC_CTRL;
  import pcs_pkg::GB_SEQ_MAX;

  localparam int BLK_W  = HEAD_W + DATA_W;
  localparam int WIDE_W = 2 * DATA_W;

  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              head_err_q, head_err_d;

  logic [HEAD_W-1:0] head_eff;
  logic              head_bad;
  logic [BLK_W-1:0]  blk;
  logic [WIDE_W-1:0] shifted;

  assign ready_o = (seq_q != SEQ_W'(GB_SEQ_MAX));

  always_comb begin
    seq_d      = seq_q;
    left_d     = left_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    head_err_d = 1'b0;
    head_eff   = head_i;
    head_bad   = 1'b0;
`ifdef PCS_TX_GEARBOX_HEAD_CHECK_EN
    // An illegal header would look like a sync slip downstream; send an errored ctrl block instead.
    if (head_i == 2'b00 || head_i == 2'b11) begin
      head_eff = SYNC_CTRL;
      head_bad = 1'b1;
    end
`endif
    blk     = {data_i, head_eff};
    // Low half merges with the 2*seq leftover bits; high half becomes the next leftover.
    shifted = {{(WIDE_W-BLK_W){1'b0}}, blk} << {seq_q, 1'b0};

    if (!ready_o) begin
      data_d  = left_q;
      left_d  = '0;
      seq_d   = '0;
      valid_d = 1'b1;
    end else if (valid_i) begin
      data_d     = shifted[DATA_W-1:0] | left_q;
      left_d     = shifted[WIDE_W-1:DATA_W];
      seq_d      = seq_q + SEQ_W'(1);
      valid_d    = 1'b1;
      head_err_d = head_bad;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seq_q      <= '0;
      left_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      head_err_q <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      left_q     <= left_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      head_err_q <= head_err_d;
    end
  end

  assign valid_o       = valid_q;
  assign tx_par_data_o = data_q;
`ifdef PCS_TX_GEARBOX_HEAD_CHECK_EN
  assign head_err_o    = head_err_q;
`else
  logic unused_head_err;
  assign unused_head_err = head_err_q ^ head_bad;
`endif

endmodule

// File: tb/tb_pcs_10g_tx_gearbox.sv
// Self-checking bench for pcs_10g_tx_gearbox: directed vectors plus a serial bitstream reference.
module tb_pcs_10g_tx_gearbox;

  logic        clk = 1'b0;
  logic        nreset;
  logic        valid_i;
  logic [1:0]  head_i;
  logic [63:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [63:0] tx_par_data_o;
`ifdef PCS_TX_GEARBOX_HEAD_CHECK_EN
  logic        head_err_o;
`endif

  pcs_10g_tx_gearbox dut (
    .clk           (clk),
    .nreset        (nreset),
    .valid_i       (valid_i),
    .head_i        (head_i),
    .data_i        (data_i),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
`ifdef PCS_TX_GEARBOX_HEAD_CHECK_EN
    .head_err_o    (head_err_o),
`endif
    .tx_par_data_o (tx_par_data_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_seq = 0;
  logic [63:0] last_data = '0;
  bit          exp_bits[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One clock: drive at the negedge, sample the registered result at the next negedge.
  task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d);
    logic        xfer, flush, bad;
    logic [1:0]  he;
    logic [65:0] b;
    logic [63:0] w;
    check("ready_o", {63'b0, ready_o}, {63'b0, exp_seq != 32});
    valid_i = v;
    head_i  = h;
    data_i  = d;
    flush   = (exp_seq == 32);
    xfer    = v && !flush;
    he      = h;
    bad     = 1'b0;
`ifdef PCS_TX_GEARBOX_HEAD_CHECK_EN
    if (h == 2'b00 || h == 2'b11) begin
      he  = 2'b10;
      bad = 1'b1;
    end
`endif
    b = {d, he};
    if (xfer)
      for (int i = 0; i < 66; i++) exp_bits.push_back(b[i]);
    @(posedge clk);
    @(negedge clk);
    if (flush) exp_seq = 0;
    else if (xfer) exp_seq++;
    check("valid_o", {63'b0, valid_o}, {63'b0, xfer || flush});
    if (xfer || flush) begin
      w = '0;
      for (int i = 0; i < 64; i++)
        if (exp_bits.size() > 0) w[i] = exp_bits.pop_front();
      check("tx_data", tx_par_data_o, w);
      last_data = w;
    end else begin
      check("tx_hold", tx_par_data_o, last_data);
    end
`ifdef PCS_TX_GEARBOX_HEAD_CHECK_EN
    check("head_err_o", {63'b0, head_err_o}, {63'b0, xfer && bad});
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {63'b0, valid_o}, 64'd0);
    check({tag, "_data"},  tx_par_data_o,    64'd0);
    check({tag, "_ready"}, {63'b0, ready_o}, 64'd1);
`ifdef PCS_TX_GEARBOX_HEAD_CHECK_EN
    check({tag, "_herr"},  {63'b0, head_err_o}, 64'd0);
`endif
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] d;
    nreset  = 1'b0;
    valid_i = 1'b0;
    head_i  = 2'b00;
    data_i  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    nreset = 1'b1;

    // First block: header lands at bit 0 one cycle after the transfer.
    step(1'b1, 2'b01, 64'h0123456789ABCDEF);
    check("first_word", tx_par_data_o, 64'h048D159E26AF37BD);

    // Fill to 32 blocks with a 3-cycle stall at seq 5, then the flush cycle.
    while (exp_seq < 32) begin
      if (exp_seq == 5) repeat (3) step(1'b0, 2'b10, 64'hDEAD_BEEF_0000_0005);
      step(1'b1, (exp_seq % 3 == 0) ? 2'b10 : 2'b01, rnd64());
    end
    check("ready_low_at_32", {63'b0, ready_o}, 64'd0);
    step(1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    check("stream_drained", 64'(exp_bits.size()), 64'd0);
    check("ready_after_wrap", {63'b0, ready_o}, 64'd1);

    // Reset mid-sequence at seq 17.
    while (exp_seq < 17) step(1'b1, 2'b01, rnd64());
    nreset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    nreset = 1'b1;
    exp_bits.delete();
    exp_seq   = 0;
    last_data = '0;
    d = 64'hA5A5_0F0F_3C3C_9669;
    step(1'b1, 2'b10, d);
    check("post_reset_bit0", tx_par_data_o, {d[61:0], 2'b10});

    // Back-to-back random blocks across several 33-cycle wraps.
    for (int i = 0; i < 100; i++)
      step(1'b1, $urandom_range(0, 1) ? 2'b01 : 2'b10, rnd64());
    while (exp_seq != 0) step(1'b1, 2'b01, rnd64());
    check("random_drained", 64'(exp_bits.size()), 64'd0);

`ifdef PCS_TX_GEARBOX_HEAD_CHECK_EN
    // Illegal header at bit 0 is emitted as ctrl.
    step(1'b1, 2'b11, 64'h1111_2222_3333_4444);
    check("bad_head_bits", {62'b0, tx_par_data_o[1:0]}, 64'd2);
    step(1'b1, 2'b01, 64'h5555_6666_7777_8888);
    step(1'b1, 2'b00, 64'h9999_AAAA_BBBB_CCCC);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
